axi4_lite_master_arbiter: RTL and testbench
===========================================

# axi4_lite_master_arbiter

Round-robin arbiter that shares one AXI4-Lite master local interface between `N_REQ` local requesters. It accepts level-held requests, grants one requester at a time, and drives the master's `USR_*` interface with that requester's registered command. It returns read data and response to the winner with a one-cycle done pulse. It sits between the requester logic and the AXI4-Lite master's local interface.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`
- `ACLK`  in  1  clock; all logic is rising-edge
- `ARESETn`  in  1  asynchronous, active-low reset
- `REQ_ENA`  in  `N_REQ`  per-requester request level
- `REQ_WSTB`  in  `N_REQ*DATA_W/8`  per-requester strobes; all-zero means read, nonzero means write
- `REQ_ADDR`  in  `N_REQ*ADDR_W`  per-requester address
- `REQ_WDATA`  in  `N_REQ*DATA_W`  per-requester write data
- `REQ_DONE`  out  `N_REQ`  one-hot, one-cycle completion pulse
- `REQ_RDATA`  out  `DATA_W`  read data, valid while `REQ_DONE` is nonzero
- `REQ_RESP`  out  2  AXI response, valid while `REQ_DONE` is nonzero
- `USR_ENA`  out  1  one-cycle command strobe to the master
- `USR_WSTB`, `USR_ADDR`, `USR_WDATA`  out  per param  registered command fields
- `USR_DONE`  in  1  master completion pulse (B or R handshake)
- `USR_RDATA`  in  `DATA_W`  master read data
- `USR_RESP`  in  2  master BRESP/RRESP
- `BUSY`  out  1  high in any state other than IDLE
- `GRANT_ID`  out  `$clog2(N_REQ)`  index of the current or last winner

## Operation
- FSM states:
  - IDLE: if any `REQ_ENA` bit is set, select a winner round-robin starting at `rr_ptr`, latch its index into `GRANT_ID`, register its WSTB/ADDR/WDATA into `USR_*`, then go to ISSUE.
  - ISSUE: `USR_ENA`=1 for exactly this cycle, then go to WAIT.
  - WAIT: hold `USR_*` stable. On `USR_DONE`, register `USR_RDATA`/`USR_RESP` into `REQ_RDATA`/`REQ_RESP`, then go to DONE.
  - DONE: `REQ_DONE[GRANT_ID]`=1. Set `rr_ptr` to `(GRANT_ID+1) mod N_REQ`, then go to IDLE.
- A requester holds `REQ_ENA` and its fields stable until it samples `REQ_DONE`, then deasserts `REQ_ENA` in the next cycle. Because of the DONE state, IDLE never re-grants a stale request.
- `USR_DONE` outside WAIT is ignored.
- `REQ_ENA` falling during ISSUE or WAIT does not abort. The transaction completes and `REQ_DONE` still pulses.
- `REQ_RDATA` is undefined for writes; it carries the registered `USR_RDATA` regardless.
- Round-robin order: search indices `rr_ptr, rr_ptr+1, …`, wrapping at `N_REQ`. The first set bit wins.

## Timing
- Reset values:
  - state IDLE, `rr_ptr`=0, `GRANT_ID`=0
  - `USR_ENA`=0; `USR_WSTB`, `USR_ADDR`, `USR_WDATA` = 0
  - `REQ_DONE`=0, `REQ_RDATA`=0, `REQ_RESP`=0, `BUSY`=0
- Request latency: `REQ_ENA` high in IDLE at cycle 0 gives `USR_ENA`=1 in cycle 1.
- Completion latency: `USR_DONE` in cycle k gives `REQ_DONE` in cycle k+1, and IDLE in cycle k+2.
- Minimum back-to-back spacing: 4 cycles between successive `USR_ENA` pulses, when `USR_DONE` arrives the cycle after ISSUE.
- `USR_DONE` coinciding with the ISSUE cycle is ignored. The master never completes in the issue cycle.
- Reset asserted mid-transaction clears everything immediately. No `REQ_DONE` is emitted and the pending request is re-arbitrated after reset.
- `USR_RESP` passes through unmodified: 2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.

## Structure
- Package `axi4_lite_arb_pkg` holds:
  - the state enum: IDLE, ISSUE, WAIT, DONE
  - `RESP_OKAY`/`RESP_SLVERR`/`RESP_DECERR` constants
- Sub-module `rr_priority_sel` (combinational) computes the winner.
  - Inputs: request vector, `rr_ptr`.
  - Outputs: winner index, any-valid flag.
- The top level holds the FSM, the command/response registers and the pointer.

## Test plan
- Single write: requester 2 with WSTB=4'hF, ADDR=0x10, WDATA=0xDEADBEEF, `USR_DONE` 3 cycles after ISSUE with RESP=0 → `USR_ENA` in cycle 1 with those fields, `REQ_DONE`=4'b0100 with RESP=0, `GRANT_ID`=2.
- Single read: requester 0 with WSTB=0, ADDR=0x20, `USR_RDATA`=0x12345678 → `REQ_DONE`=4'b0001 with `REQ_RDATA`=0x12345678.
- Fairness: all four `REQ_ENA` held continuously and re-raised after each done → grant order 0,1,2,3,0, with `USR_ENA` pulses 4 cycles apart under 1-cycle `USR_DONE`.
- Pointer wrap: after a grant to 3, requesters 1 and 3 both requesting → 1 wins, then 3.
- Error and spurious events: `USR_DONE` pulsed in IDLE → no `REQ_DONE`; `USR_RESP`=2'b10 in WAIT → `REQ_RESP`=2'b10.
- Reset mid-WAIT: `ARESETn` low for 2 cycles → all outputs at reset values, no `REQ_DONE`. After release, the still-held request is granted again with `USR_ENA` 1 cycle later.

Source files
------------

// File: rtl/axi4_lite_arb_pkg.sv
// axi4_lite_arb_pkg: shared state encoding and AXI response codes for the arbiter
package axi4_lite_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/rr_priority_sel.sv
// rr_priority_sel: first set request at or after the pointer, wrapping at N_REQ
module rr_priority_sel
    import axi4_lite_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [IW-1:0]    o_winner,
    output logic             o_valid
);
    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_winner = '0;
        w_idx    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = IW'((int'(i_rr_ptr) + i) % N_REQ);
            if (i_req[w_idx]) o_winner = w_idx;
        end
    end

    assign o_valid = |i_req;
endmodule

// File: rtl/axi4_lite_master_arbiter.sv
// axi4_lite_master_arbiter: round-robin sharing of one AXI4-Lite master local port
module axi4_lite_master_arbiter
    import axi4_lite_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
)(
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [N_REQ-1:0]             REQ_ENA,
    input  logic [N_REQ*DATA_W/8-1:0]    REQ_WSTB,
    input  logic [N_REQ*ADDR_W-1:0]      REQ_ADDR,
    input  logic [N_REQ*DATA_W-1:0]      REQ_WDATA,
    output logic [N_REQ-1:0]             REQ_DONE,
    output logic [DATA_W-1:0]            REQ_RDATA,
    output logic [1:0]                   REQ_RESP,
    output logic                         USR_ENA,
    output logic [DATA_W/8-1:0]          USR_WSTB,
    output logic [ADDR_W-1:0]            USR_ADDR,
    output logic [DATA_W-1:0]            USR_WDATA,
    input  logic                         USR_DONE,
    input  logic [DATA_W-1:0]            USR_RDATA,
    input  logic [1:0]                   USR_RESP,
    output logic                         BUSY,
    output logic [$clog2(N_REQ)-1:0]     GRANT_ID
);
    localparam int STB_W = DATA_W / 8;
    localparam int GW    = $clog2(N_REQ);

    state_t              r_state, w_next;
    logic [GW-1:0]       r_rr_ptr, r_grant_id, w_winner;
    logic                w_valid;
    logic [STB_W-1:0]    r_wstb;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata, r_rdata;
    logic [1:0]          r_resp;

    rr_priority_sel #(.N_REQ(N_REQ)) u_sel (
        .i_req    (REQ_ENA),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_valid ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = USR_DONE ? DONE : WAIT;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Command fields are captured once at grant and held until the next grant.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
            r_wstb     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_resp     <= RESP_OKAY;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_grant_id <= w_winner;
                r_wstb     <= STB_W'(REQ_WSTB >> (w_winner * STB_W));
                r_addr     <= ADDR_W'(REQ_ADDR >> (w_winner * ADDR_W));
                r_wdata    <= DATA_W'(REQ_WDATA >> (w_winner * DATA_W));
            end
            if (r_state == WAIT && USR_DONE) begin
                r_rdata <= USR_RDATA;
                r_resp  <= USR_RESP;
            end
            if (r_state == DONE)
                r_rr_ptr <= (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;
        end
    end

    assign USR_ENA   = (r_state == ISSUE);
    assign BUSY      = (r_state != IDLE);
    assign REQ_DONE  = (r_state == DONE) ? (N_REQ'(1) << r_grant_id) : '0;
    assign GRANT_ID  = r_grant_id;
    assign USR_WSTB  = r_wstb;
    assign USR_ADDR  = r_addr;
    assign USR_WDATA = r_wdata;
    assign REQ_RDATA = r_rdata;
    assign REQ_RESP  = r_resp;
endmodule

// File: tb/tb_axi4_lite_master_arbiter.sv
// tb_axi4_lite_master_arbiter: directed plan plus randomized traffic against a timing-level model
module tb_axi4_lite_master_arbiter;
    import axi4_lite_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            ACLK = 1'b0;
    logic            ARESETn = 1'b0;
    logic [N-1:0]    REQ_ENA;
    logic [N*SW-1:0] REQ_WSTB;
    logic [N*AW-1:0] REQ_ADDR;
    logic [N*DW-1:0] REQ_WDATA;
    logic [N-1:0]    REQ_DONE;
    logic [DW-1:0]   REQ_RDATA;
    logic [1:0]      REQ_RESP;
    logic            USR_ENA;
    logic [SW-1:0]   USR_WSTB;
    logic [AW-1:0]   USR_ADDR;
    logic [DW-1:0]   USR_WDATA;
    logic            USR_DONE;
    logic [DW-1:0]   USR_RDATA;
    logic [1:0]      USR_RESP;
    logic            BUSY;
    logic [1:0]      GRANT_ID;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    axi4_lite_master_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .REQ_ENA(REQ_ENA), .REQ_WSTB(REQ_WSTB), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA), .REQ_RESP(REQ_RESP),
        .USR_ENA(USR_ENA), .USR_WSTB(USR_WSTB), .USR_ADDR(USR_ADDR), .USR_WDATA(USR_WDATA),
        .USR_DONE(USR_DONE), .USR_RDATA(USR_RDATA), .USR_RESP(USR_RESP),
        .BUSY(BUSY), .GRANT_ID(GRANT_ID)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [SW-1:0] s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        REQ_ENA[i]            = 1'b1;
        REQ_WSTB[i*SW +: SW]  = s;
        REQ_ADDR[i*AW +: AW]  = a;
        REQ_WDATA[i*DW +: DW] = d;
    endtask

    task automatic wait_issue();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!USR_ENA && n < 20);
        check("issue_seen", USR_ENA, 1);
    endtask

    task automatic serve(input int lat, input logic [DW-1:0] rd, input logic [1:0] rs);
        repeat (lat) tick();
        USR_DONE  = 1'b1;
        USR_RDATA = rd;
        USR_RESP  = rs;
        tick();
        USR_DONE  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_usr_ena"}, USR_ENA, 0);
        check({tag, "_busy"}, BUSY, 0);
        check({tag, "_grant_id"}, GRANT_ID, 0);
        check({tag, "_req_done"}, REQ_DONE, 0);
        check({tag, "_usr_addr"}, USR_ADDR, 0);
        check({tag, "_usr_wstb"}, USR_WSTB, 0);
        check({tag, "_req_resp"}, REQ_RESP, 0);
    endtask

    // Model: a transaction is "age" cycles old since its grant; ISSUE is age 1,
    // completion is the first USR_DONE at age >= 2, the pulse follows one cycle later.
    int            m_age = 0, m_ptr = 0, m_gid = 0;
    bit            m_pulse = 0;
    logic [SW-1:0] m_wstb = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [1:0]    m_resp = '0;

    initial forever begin
        @(negedge ACLK);
        if (!ARESETn) begin
            m_age = 0; m_ptr = 0; m_gid = 0; m_pulse = 0;
            m_wstb = '0; m_addr = '0; m_wdata = '0; m_rdata = '0; m_resp = '0;
        end
        check("m_usr_ena", USR_ENA, m_age == 1);
        check("m_busy", BUSY, m_age >= 1);
        check("m_grant_id", GRANT_ID, m_gid);
        check("m_req_done", REQ_DONE, m_pulse ? (4'b1 << m_gid) : 4'b0);
        check("m_usr_wstb", USR_WSTB, m_wstb);
        check("m_usr_addr", USR_ADDR, m_addr);
        check("m_usr_wdata", USR_WDATA, m_wdata);
        if (m_pulse || !ARESETn) begin
            check("m_req_rdata", REQ_RDATA, m_rdata);
            check("m_req_resp", REQ_RESP, m_resp);
        end
        if (ARESETn) begin
            if (m_pulse) begin
                m_pulse = 0;
                m_age   = 0;
                m_ptr   = (m_gid + 1) % N;
            end else if (m_age >= 2 && USR_DONE) begin
                m_rdata = USR_RDATA;
                m_resp  = USR_RESP;
                m_pulse = 1;
            end else if (m_age >= 1) begin
                m_age++;
            end else if (REQ_ENA != 0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (REQ_ENA[(m_ptr + k) % N]) m_gid = (m_ptr + k) % N;
                m_wstb  = REQ_WSTB[m_gid*SW +: SW];
                m_addr  = REQ_ADDR[m_gid*AW +: AW];
                m_wdata = REQ_WDATA[m_gid*DW +: DW];
                m_age   = 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [N-1:0] ld;
    int           cnt, last, start, drain;
    bit           raise;

    initial begin
        REQ_ENA = '0; REQ_WSTB = '0; REQ_ADDR = '0; REQ_WDATA = '0;
        USR_DONE = 1'b0; USR_RDATA = '0; USR_RESP = '0;
        repeat (3) tick();
        check_reset_outputs("rst");
        ARESETn = 1'b1;

        // Fairness: all four held, 1-cycle completions
        for (int i = 0; i < N; i++) set_req(i, 4'h0, 32'h100 + i, 32'(i));
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_issue();
            check("fair_gid", GRANT_ID, k % 4);
            if (k > 0) check("fair_gap", cyc - last, 4);
            last = cyc;
            serve(1, 32'hA0 + k, RESP_OKAY);
            check("fair_done", REQ_DONE, 4'b1 << (k % 4));
            check("fair_rdata", REQ_RDATA, 32'hA0 + k);
        end
        tick();
        REQ_ENA = '0;

        // Single write from requester 2
        set_req(2, 4'hF, 32'h10, 32'hDEADBEEF);
        start = cyc;
        wait_issue();
        check("wr_latency", cyc - start, 1);
        check("wr_gid", GRANT_ID, 2);
        check("wr_wstb", USR_WSTB, 4'hF);
        check("wr_addr", USR_ADDR, 32'h10);
        check("wr_wdata", USR_WDATA, 32'hDEADBEEF);
        serve(3, 32'h0, RESP_OKAY);
        check("wr_done", REQ_DONE, 4'b0100);
        check("wr_resp", REQ_RESP, 2'b00);
        tick();
        REQ_ENA = '0;

        // Single read from requester 0
        set_req(0, 4'h0, 32'h20, 32'h0);
        wait_issue();
        check("rd_gid", GRANT_ID, 0);
        check("rd_wstb", USR_WSTB, 4'h0);
        check("rd_addr", USR_ADDR, 32'h20);
        serve(2, 32'h12345678, RESP_OKAY);
        check("rd_done", REQ_DONE, 4'b0001);
        check("rd_rdata", REQ_RDATA, 32'h12345678);
        tick();
        REQ_ENA = '0;

        // Pointer wrap: grant 3, then 1 and 3 together
        set_req(3, 4'h1, 32'h33, 32'h3);
        wait_issue();
        check("wrap_gid3", GRANT_ID, 3);
        serve(1, 32'h0, RESP_OKAY);
        tick();
        REQ_ENA = '0;
        set_req(1, 4'h0, 32'h11, 32'h1);
        set_req(3, 4'h0, 32'h33, 32'h3);
        wait_issue();
        check("wrap_first", GRANT_ID, 1);
        serve(1, 32'h0, RESP_OKAY);
        check("wrap_first_done", REQ_DONE, 4'b0010);
        tick();
        REQ_ENA[1] = 1'b0;
        wait_issue();
        check("wrap_second", GRANT_ID, 3);
        serve(1, 32'h0, RESP_OKAY);
        check("wrap_second_done", REQ_DONE, 4'b1000);
        tick();
        REQ_ENA = '0;

        // Spurious USR_DONE in IDLE and in ISSUE, then SLVERR completion
        USR_DONE = 1'b1;
        tick();
        USR_DONE = 1'b0;
        check("spur_idle_done", REQ_DONE, 0);
        check("spur_idle_busy", BUSY, 0);
        set_req(2, 4'h3, 32'h30, 32'h55);
        wait_issue();
        USR_DONE = 1'b1;
        USR_RESP = RESP_DECERR;
        tick();
        USR_DONE = 1'b0;
        tick();
        check("spur_issue_done", REQ_DONE, 0);
        check("spur_issue_busy", BUSY, 1);
        USR_DONE = 1'b1;
        USR_RESP = RESP_SLVERR;
        tick();
        USR_DONE = 1'b0;
        check("err_done", REQ_DONE, 4'b0100);
        check("err_resp", REQ_RESP, 2'b10);
        tick();
        REQ_ENA = '0;

        // Reset during WAIT, request still held afterwards
        set_req(1, 4'h0, 32'h40, 32'h0);
        wait_issue();
        tick();
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        check("midrst_hold_done", REQ_DONE, 0);
        ARESETn = 1'b1;
        tick();
        check("postrst_usr_ena", USR_ENA, 1);
        check("postrst_gid", GRANT_ID, 1);
        check("postrst_addr", USR_ADDR, 32'h40);
        serve(1, 32'h77, RESP_OKAY);
        check("postrst_done", REQ_DONE, 4'b0010);
        tick();
        REQ_ENA = '0;

        // Randomized traffic; the model process does all checking here
        cnt = 0;
        raise = 1;
        drain = 0;
        for (int t = 0; t < 1700; t++) begin
            if (t == 1500) raise = 0;
            ld = REQ_DONE;
            tick();
            for (int i = 0; i < N; i++) begin
                if (ld[i]) REQ_ENA[i] = 1'b0;
                else if (raise && !REQ_ENA[i] && $urandom_range(0, 3) == 0)
                    set_req(i, $urandom_range(0, 1) ? SW'($urandom) : '0, $urandom, $urandom);
            end
            USR_RDATA = $urandom;
            USR_RESP  = 2'($urandom);
            if (USR_ENA) begin
                cnt = $urandom_range(1, 4);
                USR_DONE = ($urandom_range(0, 3) == 0);
            end else if (cnt > 0) begin
                cnt--;
                USR_DONE = (cnt == 0);
            end else begin
                USR_DONE = ($urandom_range(0, 7) == 0);
            end
            if (!raise && !BUSY && REQ_ENA == 0) drain++;
        end
        USR_DONE = 1'b0;
        check("rand_drained", drain > 0, 1);
        check("rand_final_busy", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
